// File: rtl/qalu_pipe.sv
// Two-stage pipelined saturating Q-format ALU with MAC accumulator and valid/ready handshakes.
// Optional QALU_ROUND_EN: round half-up on the MUL/MAC Q-rescale instead of truncating.
module qalu_pipe #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 15,
  parameter int SHIFT_W = 4,
  parameter int GUARD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag,
  output logic               ovf,
  input  logic               clr_ovf
);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_ACLR, OP_SHRA, OP_SHLA,
    OP_SHRL, OP_ROL, OP_ROR, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_LT
  } op_e;

  localparam int AW = 2*WIDTH + GUARD;
  localparam int XW = AW + 2;
  localparam logic signed [XW-1:0] SAT_HI  = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO  = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] ACC_HI  = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_LO  = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  // Returns {clamped, value}: clamps v into the signed WIDTH-bit range.
  function automatic logic [WIDTH:0] sat_w(input logic signed [XW-1:0] v);
    if (v > SAT_HI) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    if (v < SAT_LO) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    return {1'b0, v[WIDTH-1:0]};
  endfunction

  function automatic logic signed [XW-1:0] rescale(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] rnd;
`ifdef QALU_ROUND_EN
    rnd = {{(XW-1){1'b0}}, 1'b1} << (FRAC-1);
`else
    rnd = '0;
`endif
    return (v + rnd) >>> FRAC;
  endfunction

  logic                      vld_p1, vld_p2, s1_adv, mv_p1;
  op_e                       op_p1;
  logic signed [WIDTH-1:0]   a_p1, b_p1;
  logic [SHIFT_W-1:0]        sh_p1;
  logic [WIDTH-1:0]          res_p2;
  logic                      flag_p2, ovf_q;
  logic signed [AW-1:0]      acc;

  assign s1_adv    = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s1_adv;
  assign mv_p1     = vld_p1 && s1_adv;
  assign out_valid = vld_p2;
  assign result    = res_p2;
  assign flag      = flag_p2;
  assign ovf       = ovf_q;

  // Stage 1: capture decoded op and operands on accept
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      op_p1 <= op_e'(opcode);
      a_p1  <= a;
      b_p1  <= b;
      sh_p1 <= shift;
    end
  end

  logic signed [2*WIDTH-1:0] a2, b2, prod;
  logic signed [XW-1:0]      ax, bx, acc_x, prod_x, mac_sum, mac_clamp;
  logic [WIDTH-1:0]          ua;
  logic [WIDTH:0]            sv;
  logic                      flag_c, acc_upd, acc_of;
  logic [AW-1:0]             acc_nxt;
  int                        shn;

  assign a2      = {{WIDTH{a_p1[WIDTH-1]}}, a_p1};
  assign b2      = {{WIDTH{b_p1[WIDTH-1]}}, b_p1};
  assign prod    = a2 * b2;
  assign ax      = {{(XW-WIDTH){a_p1[WIDTH-1]}}, a_p1};
  assign bx      = {{(XW-WIDTH){b_p1[WIDTH-1]}}, b_p1};
  assign prod_x  = {{(XW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_x   = {{(XW-AW){acc[AW-1]}}, acc};
  assign mac_sum = acc_x + prod_x;
  assign ua      = a_p1;

  always_comb begin
    sv        = '0;
    flag_c    = 1'b0;
    acc_upd   = 1'b0;
    acc_of    = 1'b0;
    mac_clamp = mac_sum;
    acc_nxt   = acc;
    shn       = (int'(sh_p1) >= WIDTH) ? WIDTH-1 : int'(sh_p1);
    if (mac_sum > ACC_HI) begin
      mac_clamp = ACC_HI;
      acc_of    = 1'b1;
    end else if (mac_sum < ACC_LO) begin
      mac_clamp = ACC_LO;
      acc_of    = 1'b1;
    end
    case (op_p1)
      OP_ADD:  sv = sat_w(ax + bx);
      OP_SUB:  sv = sat_w(ax - bx);
      OP_MUL:  sv = sat_w(rescale(prod_x));
      OP_MAC: begin
        sv        = sat_w(rescale(mac_clamp));
        sv[WIDTH] = sv[WIDTH] | acc_of;
        acc_nxt   = mac_clamp[AW-1:0];
        acc_upd   = 1'b1;
      end
      OP_ACLR: begin
        acc_nxt = '0;
        acc_upd = 1'b1;
      end
      OP_SHRA: sv = {1'b0, a_p1 >>> shn};
      OP_SHLA: sv = sat_w(ax <<< shn);
      OP_SHRL: sv = {1'b0, ua >> shn};
      OP_ROL:  sv = {1'b0, (ua << shn) | (ua >> (WIDTH - shn))};
      OP_ROR:  sv = {1'b0, (ua >> shn) | (ua << (WIDTH - shn))};
      OP_AND:  sv = {1'b0, ua & b_p1};
      OP_OR:   sv = {1'b0, ua | b_p1};
      OP_XOR:  sv = {1'b0, ua ^ b_p1};
      OP_EQ:   flag_c = (a_p1 == b_p1);
      OP_LT:   flag_c = (a_p1 < b_p1);
      default: sv = '0;
    endcase
  end

  // Stage 2: register result, flag, valid; commit accumulator and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      flag_p2 <= 1'b0;
      ovf_q   <= 1'b0;
      acc     <= '0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s1_adv)   vld_p2 <= vld_p1;
      if (mv_p1) begin
        res_p2  <= sv[WIDTH-1:0];
        flag_p2 <= flag_c;
        if (acc_upd) acc <= acc_nxt;
      end
      if (mv_p1 && sv[WIDTH]) ovf_q <= 1'b1;
      else if (clr_ovf)       ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qalu_pipe.sv
// Scoreboard bench for qalu_pipe (WIDTH=16, FRAC=15): directed vectors plus randomized traffic and backpressure.
module tb_qalu_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic [3:0]  opcode = '0, shift = '0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, flag, ovf;
  logic [15:0] result;

  qalu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] r; logic f; logic o; } exp_t;
  exp_t   sbq[$];
  int     checks = 0, passed = 0;
  longint acc_m = 0;
  bit     stk = 0;
  bit     rnd_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
  endtask

  function automatic logic [15:0] satm(input longint v, inout bit ov);
    if (v > 32767)  begin ov = 1; return 16'h7FFF; end
    if (v < -32768) begin ov = 1; return 16'h8000; end
    return v[15:0];
  endfunction

  // Reference model: plain integer arithmetic on the op definitions
  task automatic model(input int op, input logic [15:0] ia, input logic [15:0] ib,
                       input int ish, output exp_t e);
    longint va, vb, rnd, lim, t64;
    int n;
    bit ov;
    logic [15:0] t;
    va = longint'($signed(ia));
    vb = longint'($signed(ib));
`ifdef QALU_ROUND_EN
    rnd = 64'sd16384;
`else
    rnd = 0;
`endif
    lim = longint'(1) <<< 39;
    n = (ish > 15) ? 15 : ish;
    ov = 0;
    e.r = '0;
    e.f = 1'b0;
    case (op)
      1:  e.r = satm(va + vb, ov);
      2:  e.r = satm(va - vb, ov);
      3:  e.r = satm((va * vb + rnd) >>> 15, ov);
      4: begin
        acc_m = acc_m + va * vb;
        if (acc_m > lim - 1) begin acc_m = lim - 1; ov = 1; end
        else if (acc_m < -lim) begin acc_m = -lim; ov = 1; end
        e.r = satm((acc_m + rnd) >>> 15, ov);
      end
      5:  acc_m = 0;
      6: begin t64 = va >>> n; e.r = t64[15:0]; end
      7:  e.r = satm(va * (longint'(1) << n), ov);
      8:  e.r = ia >> n;
      9: begin t = ia; repeat (n) t = {t[14:0], t[15]}; e.r = t; end
      10: begin t = ia; repeat (n) t = {t[0], t[15:1]}; e.r = t; end
      11: e.r = ia & ib;
      12: e.r = ia | ib;
      13: e.r = ia ^ ib;
      14: e.f = (ia == ib);
      15: e.f = (va < vb);
      default: e.r = '0;
    endcase
    if (ov) stk = 1;
    e.o = stk;
  endtask

  task automatic issue(input int op, input logic [15:0] ia, input logic [15:0] ib, input int ish);
    bit ok;
    int n;
    exp_t e;
    ok = 0;
    n = 0;
    in_valid = 1'b1; opcode = op[3:0]; a = ia; b = ib; shift = ish[3:0];
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) begin
      model(op, ia, ib, ish, e);
      sbq.push_back(e);
    end else begin
      checks++;
      $display("FAIL issue_timeout op=%0d in_ready=%0b required=1", op, in_ready);
    end
  endtask

  task automatic issue_d(input int op, input logic [15:0] ia, input logic [15:0] ib, input int ish,
                         input logic [15:0] er, input logic ef);
    issue(op, ia, ib, ish);
    if (sbq.size() > 0) begin
      sbq[sbq.size()-1].r = er;
      sbq[sbq.size()-1].f = ef;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    stk = 0;
    chk("ovf_clear", ovf, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output result=%0h required=none", result);
      end else begin
        chk("result", result, sbq[0].r);
        chk("flag", flag, sbq[0].f);
        chk("ovf", ovf, sbq[0].o);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    int op;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    issue_d(1, 16'h7000, 16'h2000, 0, 16'h7FFF, 0);
    drain();
    chk("add_ovf_sticky", ovf, 1);
    clr();

    issue_d(3, 16'h4000, 16'h4000, 0, 16'h2000, 0);
`ifdef QALU_ROUND_EN
    issue_d(3, 16'h0001, 16'h4000, 0, 16'h0001, 0);
`else
    issue_d(3, 16'h0001, 16'h4000, 0, 16'h0000, 0);
`endif
    issue_d(3, 16'h8000, 16'h8000, 0, 16'h7FFF, 0);
    drain();
    clr();

    issue_d(5, 16'h1234, 16'h5678, 0, 16'h0000, 0);
    issue_d(4, 16'h4000, 16'h4000, 0, 16'h2000, 0);
    issue_d(4, 16'h4000, 16'h4000, 0, 16'h4000, 0);
    issue_d(4, 16'h4000, 16'h4000, 0, 16'h6000, 0);
    issue_d(4, 16'h4000, 16'h4000, 0, 16'h7FFF, 0);
    issue_d(4, 16'hC000, 16'h4000, 0, 16'h6000, 0);
    drain();
    clr();

    issue_d(10, 16'h8001, 16'h0000, 1, 16'hC000, 0);
    issue_d(9,  16'h8001, 16'h0000, 1, 16'h0003, 0);
    issue_d(6,  16'h8000, 16'h0000, 15, 16'hFFFF, 0);
    issue_d(14, 16'h0005, 16'h0005, 0, 16'h0000, 1);
    issue_d(15, 16'h8000, 16'h0001, 0, 16'h0000, 1);
    issue_d(7,  16'hC000, 16'h0000, 1, 16'h8000, 0);
    issue_d(8,  16'h8000, 16'h0000, 15, 16'h0001, 0);
    issue_d(0,  16'hFFFF, 16'hFFFF, 3, 16'h0000, 0);
    issue_d(7,  16'h4000, 16'h0000, 1, 16'h7FFF, 0);
    drain();
    clr();

    // overflow entering stage 2 while clr_ovf is high: set must win
    issue_d(2, 16'h8000, 16'h0001, 0, 16'h8000, 0);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    drain();
    chk("set_beats_clr", ovf, 1);
    clr();

    out_ready = 1'b0;
    issue_d(1, 16'h0001, 16'h0002, 0, 16'h0003, 0);
    issue_d(1, 16'h0003, 16'h0004, 0, 16'h0007, 0);
    chk("bp_in_ready_low", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_out_valid_held", out_valid, 1);
    fork
      begin
        issue_d(1, 16'h0005, 16'h0006, 0, 16'h000B, 0);
        issue_d(1, 16'h0007, 16'h0008, 0, 16'h000F, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    issue(2, 16'h1111, 16'h0001, 0);
    issue(13, 16'h00FF, 16'h0F0F, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    sbq.delete();
    acc_m = 0;
    stk = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_out_valid_after", out_valid, 0);
    issue_d(4, 16'h4000, 16'h4000, 0, 16'h2000, 0);
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      op = $urandom % 16;
      ra = $urandom;
      rb = $urandom;
      case ($urandom % 8)
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'h8000;
        3: rb = ra;
        default: ;
      endcase
      issue(op, ra, rb, $urandom % 16);
      if (i % 30 == 29) begin
        drain();
        clr();
      end
    end
    rnd_ready = 0;
    #2;
    out_ready = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
